// File: rtl/hex_display_pkg.sv
// Shared types, constants and the glyph lookup for the hex display pager.
package hex_display_pkg;

  // One seven-segment glyph: bit 0 is segment a, bit 6 is segment g, active-low.
  typedef logic [6:0] seg_t;

  // Glyph with every segment off, used for blanked digits and for reset.
  localparam seg_t SEG_BLANK = 7'h7F;

  // Hex glyph table indexed by nibble value 0..F.
  localparam seg_t GLYPH_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Translate one nibble into its active-low segment pattern.
  function automatic seg_t nibbleToGlyph(input logic [3:0] nib);
    return GLYPH_TABLE[nib];
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronises a raw active-low pushbutton, debounces it and emits a
// single-cycle pulse when the accepted level falls (a press). A release
// produces nothing.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n_i,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;

  logic             sync0_q;
  logic             sync1_q;
  logic             level_q;
  logic             level_d;
  logic             press_q;
  logic             press_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Two-flop synchroniser; idles high so a reset never looks like a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync0_q <= 1'b1;
      sync1_q <= 1'b1;
    end else begin
      sync0_q <= btn_n_i;
      sync1_q <= sync0_q;
    end
  end

  // Count cycles of disagreement; once the new level has held long enough, accept it.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync1_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
        level_d = sync1_q;
        press_d = ~sync1_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Accepted level, debounce counter and press pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/hex_display_pager.sv
// Pages through several 32-bit channels on a row of seven-segment digits.
// The page advances on a debounced button press or an auto-scroll timer,
// can be frozen, and optionally blanks leading zeros.
module hex_display_pager
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_W       = 32,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int AUTO_CYC     = 50000000
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CHANNELS*DATA_W-1:0]     ch_data,
  input  logic                               next_btn_n,
  input  logic                               auto_en,
  input  logic                               freeze,
  input  logic                               blank_lz,
  output logic [NUM_DIGITS*7-1:0]            hex,
  output logic [$clog2(NUM_CHANNELS)-1:0]    page_idx,
  output logic                               page_tick
);

  localparam int PAGE_W = $clog2(NUM_CHANNELS);
  localparam int SHOW_W = NUM_DIGITS * 4;
  localparam int AUTO_W = (AUTO_CYC > 1) ? $clog2(AUTO_CYC) : 1;

  logic              pressEvt;
  logic              autoEvt;
  logic              advance;

  logic [AUTO_W-1:0] autoCnt_q;
  logic [AUTO_W-1:0] autoCnt_d;
  logic [PAGE_W-1:0] pageIdx_q;
  logic [PAGE_W-1:0] pageIdx_d;
  logic              pageTick_q;
  logic              pageTick_d;
  logic [SHOW_W-1:0] value_q;
  logic [SHOW_W-1:0] value_d;
  logic [NUM_DIGITS*7-1:0] hex_q;
  logic [NUM_DIGITS*7-1:0] hex_d;
  logic [3:0]        nib;
  logic              keepBlank;

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_btn_debounce (
    .clk     (clk),
    .reset   (reset),
    .btn_n_i (next_btn_n),
    .press_o (pressEvt)
  );

  // Events only move the page while not frozen; press and auto together still count once.
  always_comb begin
    autoEvt = auto_en & (autoCnt_q == AUTO_W'(AUTO_CYC - 1));
    advance = ~freeze & (pressEvt | autoEvt);
  end

  // Auto timer: cleared when disabled, held when frozen, restarted by a press or its own wrap.
  always_comb begin
    autoCnt_d = autoCnt_q;
    if (!auto_en) begin
      autoCnt_d = '0;
    end else if (freeze) begin
      autoCnt_d = autoCnt_q;
    end else if (pressEvt || autoEvt) begin
      autoCnt_d = '0;
    end else begin
      autoCnt_d = autoCnt_q + 1'b1;
    end
  end

  // Page index wraps from the last channel back to channel 0; the tick marks the change.
  always_comb begin
    pageIdx_d  = pageIdx_q;
    pageTick_d = advance;
    if (advance) begin
      if (pageIdx_q == PAGE_W'(NUM_CHANNELS - 1)) begin
        pageIdx_d = '0;
      end else begin
        pageIdx_d = pageIdx_q + 1'b1;
      end
    end
  end

  // Capture only the displayable low nibbles of the selected channel unless frozen.
  always_comb begin
    value_d = value_q;
    if (!freeze) begin
      value_d = ch_data[int'(pageIdx_q) * DATA_W +: SHOW_W];
    end
  end

  // Walk digits from the top down; blanking stays on until the first non-zero nibble.
  always_comb begin
    hex_d     = '0;
    nib       = '0;
    keepBlank = blank_lz;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      nib = value_q[4*k +: 4];
      if (nib != 4'h0) begin
        keepBlank = 1'b0;
      end
      hex_d[7*k +: 7] = keepBlank ? SEG_BLANK : nibbleToGlyph(nib);
    end
    hex_d[6:0] = nibbleToGlyph(value_q[3:0]);
  end

  // All pager state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      autoCnt_q  <= '0;
      pageIdx_q  <= '0;
      pageTick_q <= 1'b0;
      value_q    <= '0;
      hex_q      <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      autoCnt_q  <= autoCnt_d;
      pageIdx_q  <= pageIdx_d;
      pageTick_q <= pageTick_d;
      value_q    <= value_d;
      hex_q      <= hex_d;
    end
  end

  assign hex       = hex_q;
  assign page_idx  = pageIdx_q;
  assign page_tick = pageTick_q;

endmodule

// File: tb/tb_hex_display_pager.sv
// Self-checking bench for hex_display_pager with a small debounce and auto period.
module tb_hex_display_pager;

  localparam int ND = 6;
  localparam int NC = 4;
  localparam int DW = 32;
  localparam int DB = 4;
  localparam int AC = 10;

  localparam logic [6:0] TB_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic             clk = 1'b0;
  logic             reset;
  logic [NC*DW-1:0] chData;
  logic             nextBtnN;
  logic             autoEn;
  logic             freeze;
  logic             blankLz;
  logic [ND*7-1:0]  hex;
  logic [1:0]       pageIdx;
  logic             pageTick;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [1:0]      expPageQ[$];
  logic [ND*7-1:0] expHexQ[$];

  always #5 clk = ~clk;

  hex_display_pager #(
    .NUM_DIGITS  (ND),
    .NUM_CHANNELS(NC),
    .DATA_W      (DW),
    .DEBOUNCE_CYC(DB),
    .AUTO_CYC    (AC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ch_data    (chData),
    .next_btn_n (nextBtnN),
    .auto_en    (autoEn),
    .freeze     (freeze),
    .blank_lz   (blankLz),
    .hex        (hex),
    .page_idx   (pageIdx),
    .page_tick  (pageTick)
  );

  // Reference display image for a channel value.
  function automatic logic [ND*7-1:0] modelHex(input logic [31:0] v, input logic blank);
    logic [ND*7-1:0] r;
    int top = 0;
    r = '0;
    for (int k = 0; k < ND; k++) if (v[4*k +: 4] != 4'h0) top = k;
    for (int k = 0; k < ND; k++) r[7*k +: 7] = (blank && k > top) ? 7'h7F : TB_GLYPH[v[4*k +: 4]];
    return r;
  endfunction

  function automatic logic [31:0] chVal(input int c);
    return chData[c*DW +: DW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset    = 1'b1;
    nextBtnN = 1'b1;
    autoEn   = 1'b0;
    freeze   = 1'b0;
    blankLz  = 1'b0;
    expPageQ.delete();
    expHexQ.delete();
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic pressAsync(input int holdCyc);
    fork
      begin
        nextBtnN = 1'b0;
        repeat (holdCyc) tick();
        nextBtnN = 1'b1;
      end
    join_none
  endtask

  task automatic waitTick(input int budget, output int cyc, output bit seen);
    cyc  = 0;
    seen = 1'b0;
    while (cyc < budget && !seen) begin
      tick();
      cyc++;
      if (pageTick === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [ND*7-1:0] eh;
    reset = 1'b1; nextBtnN = 1'b1; autoEn = 1'b0; freeze = 1'b0; blankLz = 1'b0;
    repeat (3) tick();
    nCompared++;
    if (hex !== {ND{7'h7F}}) begin nMismatched++; $display("[TB] FAIL reset_hex: got %h expected %h", hex, {ND{7'h7F}}); end
    nCompared++;
    if (pageIdx !== 2'd0) begin nMismatched++; $display("[TB] FAIL reset_page: got %0d expected 0", pageIdx); end
    nCompared++;
    if (pageTick !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_tick: got %b expected 0", pageTick); end
    reset = 1'b0;
    tick();
    nCompared++;
    if (hex !== {ND{7'h40}}) begin nMismatched++; $display("[TB] FAIL reset_lat1: got %h expected %h", hex, {ND{7'h40}}); end
    tick();
    eh = {7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    nCompared++;
    if (hex !== eh) begin nMismatched++; $display("[TB] FAIL reset_lat2: got %h expected %h", hex, eh); end
  endtask

  task automatic test_bounce();
    int highCycles = 0;
    logic [1:0] ep;
    logic [ND*7-1:0] eh;
    doReset();
    expPageQ.push_back(2'd1);
    expHexQ.push_back(modelHex(chVal(1), 1'b0));
    for (int i = 0; i < 40; i++) begin
      nextBtnN = (i < 10) ? (i == 3) : 1'b1;
      tick();
      if (pageTick === 1'b1) begin
        highCycles++;
        if (expPageQ.size() != 0) begin
          ep = expPageQ.pop_front();
          nCompared++;
          if (pageIdx !== ep) begin nMismatched++; $display("[TB] FAIL bounce_page: got %0d expected %0d", pageIdx, ep); end
        end
      end
    end
    nCompared++;
    if (highCycles != 1) begin nMismatched++; $display("[TB] FAIL bounce_ticks: got %0d expected 1", highCycles); end
    eh = expHexQ.pop_front();
    nCompared++;
    if (hex !== eh) begin nMismatched++; $display("[TB] FAIL bounce_hex: got %h expected %h", hex, eh); end
  endtask

  task automatic test_press_wrap();
    int cyc;
    bit seen;
    int spurious;
    logic [1:0] ep;
    logic [ND*7-1:0] eh;
    doReset();
    for (int p = 0; p < 4; p++) begin
      expPageQ.push_back(2'((p + 1) % NC));
      expHexQ.push_back(modelHex(chVal((p + 1) % NC), 1'b0));
      pressAsync(8);
      waitTick(20, cyc, seen);
      ep = expPageQ.pop_front();
      nCompared++;
      if (!seen || pageIdx !== ep) begin nMismatched++; $display("[TB] FAIL wrap_page%0d: got %0d seen %0b expected %0d", p, pageIdx, seen, ep); end
      tick();
      nCompared++;
      if (pageTick !== 1'b0) begin nMismatched++; $display("[TB] FAIL wrap_tick_width%0d: got %b expected 0", p, pageTick); end
      tick();
      eh = expHexQ.pop_front();
      nCompared++;
      if (hex !== eh) begin nMismatched++; $display("[TB] FAIL wrap_hex%0d: got %h expected %h", p, hex, eh); end
      spurious = 0;
      repeat (14) begin
        tick();
        if (pageTick === 1'b1) spurious++;
      end
      nCompared++;
      if (spurious != 0) begin nMismatched++; $display("[TB] FAIL wrap_release%0d: got %0d ticks expected 0", p, spurious); end
    end
  endtask

  task automatic test_auto();
    int cyc;
    bit seen;
    logic [1:0] ep;
    int expCyc [4] = '{10, 10, 7, 10};
    doReset();
    autoEn = 1'b1;
    for (int s = 0; s < 4; s++) begin
      expPageQ.push_back(2'((s + 1) % NC));
      if (s == 2) pressAsync(8);
      waitTick(15, cyc, seen);
      ep = expPageQ.pop_front();
      nCompared++;
      if (!seen || cyc != expCyc[s]) begin nMismatched++; $display("[TB] FAIL auto_period%0d: got %0d cycles expected %0d", s, cyc, expCyc[s]); end
      nCompared++;
      if (pageIdx !== ep) begin nMismatched++; $display("[TB] FAIL auto_page%0d: got %0d expected %0d", s, pageIdx, ep); end
    end
    autoEn = 1'b0;
  endtask

  task automatic test_simul_freeze();
    int cyc;
    bit seen;
    int badCycles;
    logic [1:0] ep;
    logic [31:0] oldVal;
    logic [ND*7-1:0] eh;
    doReset();
    autoEn = 1'b1;
    expPageQ.push_back(2'd1);
    expPageQ.push_back(2'd2);
    expPageQ.push_back(2'd3);
    waitTick(15, cyc, seen);
    ep = expPageQ.pop_front();
    nCompared++;
    if (!seen || pageIdx !== ep) begin nMismatched++; $display("[TB] FAIL simul_first: got %0d expected %0d", pageIdx, ep); end
    repeat (3) tick();
    pressAsync(8);
    waitTick(15, cyc, seen);
    ep = expPageQ.pop_front();
    nCompared++;
    if (!seen || cyc != 7) begin nMismatched++; $display("[TB] FAIL simul_coincide: got %0d cycles expected 7", cyc); end
    nCompared++;
    if (pageIdx !== ep) begin nMismatched++; $display("[TB] FAIL simul_page: got %0d expected %0d", pageIdx, ep); end
    tick();
    nCompared++;
    if (pageTick !== 1'b0 || pageIdx !== ep) begin nMismatched++; $display("[TB] FAIL simul_single: got tick %b page %0d expected 0 and %0d", pageTick, pageIdx, ep); end
    waitTick(15, cyc, seen);
    ep = expPageQ.pop_front();
    nCompared++;
    if (!seen || cyc != 9 || pageIdx !== ep) begin nMismatched++; $display("[TB] FAIL simul_next: got %0d cycles page %0d expected 9 and %0d", cyc, pageIdx, ep); end
    autoEn = 1'b0;
    repeat (3) tick();
    oldVal = chVal(3);
    eh = modelHex(oldVal, 1'b0);
    nCompared++;
    if (hex !== eh) begin nMismatched++; $display("[TB] FAIL freeze_before: got %h expected %h", hex, eh); end
    freeze = 1'b1;
    chData[3*DW +: DW] = 32'h00DEAD42;
    pressAsync(8);
    badCycles = 0;
    repeat (20) begin
      tick();
      if (pageTick !== 1'b0 || pageIdx !== 2'd3 || hex !== eh) badCycles++;
    end
    nCompared++;
    if (badCycles != 0) begin nMismatched++; $display("[TB] FAIL freeze_hold: got %0d bad cycles expected 0", badCycles); end
    freeze = 1'b0;
    badCycles = 0;
    repeat (20) begin
      tick();
      if (pageTick !== 1'b0) badCycles++;
    end
    nCompared++;
    if (badCycles != 0 || pageIdx !== 2'd3) begin nMismatched++; $display("[TB] FAIL freeze_pending: got %0d ticks page %0d expected 0 and 3", badCycles, pageIdx); end
    eh = modelHex(32'h00DEAD42, 1'b0);
    nCompared++;
    if (hex !== eh) begin nMismatched++; $display("[TB] FAIL freeze_after: got %h expected %h", hex, eh); end
    chData[3*DW +: DW] = oldVal;
  endtask

  task automatic test_blank();
    logic [31:0] vals  [5] = '{32'h00000000, 32'h00000A00, 32'hFF000012, 32'h00800000, 32'h00000000};
    logic        blanks[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] saved;
    logic [ND*7-1:0] eh;
    doReset();
    saved = chVal(0);
    expHexQ.push_back({{5{7'h7F}}, 7'h40});
    expHexQ.push_back({{3{7'h7F}}, 7'h08, 7'h40, 7'h40});
    expHexQ.push_back({{4{7'h7F}}, 7'h79, 7'h24});
    expHexQ.push_back(modelHex(32'h00800000, 1'b1));
    expHexQ.push_back({ND{7'h40}});
    for (int i = 0; i < 5; i++) begin
      blankLz = blanks[i];
      chData[DW-1:0] = vals[i];
      tick();
      tick();
      eh = expHexQ.pop_front();
      nCompared++;
      if (hex !== eh) begin nMismatched++; $display("[TB] FAIL blank%0d: got %h expected %h", i, hex, eh); end
    end
    chData[DW-1:0] = saved;
    blankLz = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit seen;
    int ticks = 0;
    doReset();
    nextBtnN = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    nextBtnN = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (30) begin
      tick();
      if (pageTick === 1'b1) ticks++;
    end
    nCompared++;
    if (ticks != 0 || pageIdx !== 2'd0) begin nMismatched++; $display("[TB] FAIL midreset_btn: got %0d ticks page %0d expected 0 and 0", ticks, pageIdx); end
    autoEn = 1'b1;
    repeat (6) tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    waitTick(15, cyc, seen);
    nCompared++;
    if (!seen || cyc != 10 || pageIdx !== 2'd1) begin nMismatched++; $display("[TB] FAIL midreset_auto: got %0d cycles page %0d expected 10 and 1", cyc, pageIdx); end
    autoEn = 1'b0;
  endtask

  initial begin
    chData = '0;
    chData[0*DW +: DW] = 32'h00ABCDEF;
    chData[1*DW +: DW] = 32'h00000123;
    chData[2*DW +: DW] = 32'h00C0FFEE;
    chData[3*DW +: DW] = 32'h00000007;
    test_reset();
    test_bounce();
    test_press_wrap();
    test_auto();
    test_simul_freeze();
    test_blank();
    test_reset_mid();
    nCompared++;
    if (expPageQ.size() != 0) begin nMismatched++; $display("[TB] FAIL scoreboard_drain: got %0d left expected 0", expPageQ.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
